// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU and a loader (DMA).
// One access in flight at a time; a stuck access is aborted after TIMEOUT cycles.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  // CPU port
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_stall,
  // loader port
  input  logic        dma_req,
  input  logic [3:0]  dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic [31:0] dma_rdata,
  output logic        dma_done,
  // memory port
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WE_W   = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [WE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } acc_t;

  state_t            state_q, state_d;
  logic              grant_cpu_q, grant_cpu_d;
  logic              last_dma_q, last_dma_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic              mem_en_d;
  logic [WE_W-1:0]   mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_d;
  logic              cpu_done_d;
  logic              dma_done_d;
  logic              err_d;

  logic              pick_cpu;
  acc_t              cpu_acc;
  acc_t              dma_acc;
  acc_t              sel_acc;

  // CPU wins when alone, or on a tie when the loader was served last.
  assign pick_cpu = cpu_req & (~dma_req | last_dma_q);

  assign cpu_acc  = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign dma_acc  = '{we: dma_we, addr: dma_addr, wdata: dma_wdata};
  assign sel_acc  = pick_cpu ? cpu_acc : dma_acc;

  assign cpu_stall = cpu_req & ~cpu_done;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    grant_cpu_d = grant_cpu_q;
    last_dma_d  = last_dma_q;
    wait_cnt_d  = wait_cnt_q;
    mem_en_d    = mem_en;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    cpu_rdata_d = cpu_rdata;
    dma_rdata_d = dma_rdata;
    cpu_done_d  = 1'b0;
    dma_done_d  = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        mem_en_d = 1'b0;
        mem_we_d = '0;
        if (cpu_req || dma_req) begin
          grant_cpu_d = pick_cpu;
          mem_en_d    = 1'b1;
          mem_we_d    = sel_acc.we;
          mem_addr_d  = sel_acc.addr & WORD_MASK;
          mem_wdata_d = sel_acc.wdata;
          wait_cnt_d  = '0;
          state_d     = BUSY;
        end
      end

      BUSY: begin
        // An ack in the limit cycle still counts as success.
        if (mem_ack || (wait_cnt_q == CNT_LIMIT)) begin
          if (grant_cpu_q) begin
            cpu_rdata_d = mem_ack ? mem_rdata : '0;
          end else begin
            dma_rdata_d = mem_ack ? mem_rdata : '0;
          end
          cpu_done_d = grant_cpu_q;
          dma_done_d = ~grant_cpu_q;
          err_d      = ~mem_ack;
          mem_en_d   = 1'b0;
          mem_we_d   = '0;
          state_d    = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        last_dma_d = ~grant_cpu_q;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cpu_q <= 1'b0;
      last_dma_q  <= 1'b1;
      wait_cnt_q  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata   <= '0;
      dma_rdata   <= '0;
      cpu_done    <= 1'b0;
      dma_done    <= 1'b0;
      err         <= 1'b0;
    end else begin
      grant_cpu_q <= grant_cpu_d;
      last_dma_q  <= last_dma_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_en      <= mem_en_d;
      mem_we      <= mem_we_d;
      mem_addr    <= mem_addr_d;
      mem_wdata   <= mem_wdata_d;
      cpu_rdata   <= cpu_rdata_d;
      dma_rdata   <= dma_rdata_d;
      cpu_done    <= cpu_done_d;
      dma_done    <= dma_done_d;
      err         <= err_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-cycle vector table plus hand-built timeout/reset sequences.
module tb_dmem_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        cpu_stall;
  logic        dma_req;
  logic [3:0]  dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_done;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;

  dmem_arbiter #(.TIMEOUT(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_done  (cpu_done),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_done  (dma_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: inputs driven during the cycle, outputs expected during the same cycle.
  typedef struct {
    logic        rst;
    logic        creq;
    logic [3:0]  cwe;
    logic [31:0] caddr;
    logic [31:0] cwdata;
    logic        dreq;
    logic [3:0]  dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        ack;
    logic [31:0] mrd;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] crd;
    logic        cdone;
    logic [31:0] drd;
    logic        ddone;
    logic        err;
    logic        stall;
  } vec_t;

  vec_t tbl[$];
  vec_t v;
  int   n_vec;
  int   n_bad;

  task automatic apply(input vec_t t, input string name, input int idx);
    @(negedge clk);
    reset     = t.rst;
    cpu_req   = t.creq;
    cpu_we    = t.cwe;
    cpu_addr  = t.caddr;
    cpu_wdata = t.cwdata;
    dma_req   = t.dreq;
    dma_we    = t.dwe;
    dma_addr  = t.daddr;
    dma_wdata = t.dwdata;
    mem_ack   = t.ack;
    mem_rdata = t.mrd;
    #1;
    n_vec++;
    if (mem_en !== t.en || mem_we !== t.we || mem_addr !== t.addr ||
        mem_wdata !== t.wdata || cpu_rdata !== t.crd || cpu_done !== t.cdone ||
        dma_rdata !== t.drd || dma_done !== t.ddone || err !== t.err ||
        cpu_stall !== t.stall) begin
      n_bad++;
      $display("FAIL %s[%0d] got en=%b we=%h addr=%h wdata=%h crd=%h cdone=%b drd=%h ddone=%b err=%b stall=%b | want en=%b we=%h addr=%h wdata=%h crd=%h cdone=%b drd=%h ddone=%b err=%b stall=%b",
               name, idx, mem_en, mem_we, mem_addr, mem_wdata, cpu_rdata, cpu_done,
               dma_rdata, dma_done, err, cpu_stall, t.en, t.we, t.addr, t.wdata,
               t.crd, t.cdone, t.drd, t.ddone, t.err, t.stall);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    reset     = 1'b1;
    cpu_req   = 1'b0;
    cpu_we    = '0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    dma_req   = 1'b0;
    dma_we    = '0;
    dma_addr  = '0;
    dma_wdata = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);

    // Reset values, CPU read with one-cycle ack, stray ack in IDLE, reset from IDLE.
    v = '{default: '0};
    v.rst = 1'b1; tbl.push_back(v);
    v.rst = 1'b0; v.creq = 1'b1; v.caddr = 32'h0000_0106; v.stall = 1'b1; tbl.push_back(v);
    v.ack = 1'b1; v.mrd = 32'hDEAD_BEEF; v.en = 1'b1; v.addr = 32'h0000_0104; tbl.push_back(v);
    v.ack = 1'b0; v.mrd = '0; v.en = 1'b0; v.crd = 32'hDEAD_BEEF; v.cdone = 1'b1; v.stall = 1'b0;
    tbl.push_back(v);
    v.creq = 1'b0; v.cdone = 1'b0; tbl.push_back(v);
    v.ack = 1'b1; v.mrd = 32'h5555_5555; tbl.push_back(v);
    v.ack = 1'b0; v.mrd = '0; tbl.push_back(v);
    v.rst = 1'b1; tbl.push_back(v);

    // Contention: CPU first after reset, then alternating.
    v.rst = 1'b0; v.creq = 1'b1; v.caddr = 32'h0000_0200;
    v.dreq = 1'b1; v.dwe = 4'hF; v.daddr = 32'h0000_0300; v.dwdata = 32'hAAAA_5555;
    v.addr = '0; v.crd = '0; v.stall = 1'b1; tbl.push_back(v);
    v.ack = 1'b1; v.mrd = 32'h1111_1111; v.en = 1'b1; v.addr = 32'h0000_0200; tbl.push_back(v);
    v.ack = 1'b0; v.mrd = '0; v.en = 1'b0; v.crd = 32'h1111_1111; v.cdone = 1'b1; v.stall = 1'b0;
    tbl.push_back(v);
    v.caddr = 32'h0000_0204; v.cdone = 1'b0; v.stall = 1'b1; tbl.push_back(v);
    v.ack = 1'b1; v.mrd = 32'h2222_2222; v.en = 1'b1; v.we = 4'hF; v.addr = 32'h0000_0300;
    v.wdata = 32'hAAAA_5555; tbl.push_back(v);
    v.ack = 1'b0; v.mrd = '0; v.en = 1'b0; v.we = '0; v.drd = 32'h2222_2222; v.ddone = 1'b1;
    tbl.push_back(v);
    v.ddone = 1'b0; tbl.push_back(v);
    v.ack = 1'b1; v.mrd = 32'h3333_3333; v.en = 1'b1; v.addr = 32'h0000_0204; v.wdata = '0;
    tbl.push_back(v);
    v.ack = 1'b0; v.mrd = '0; v.en = 1'b0; v.crd = 32'h3333_3333; v.cdone = 1'b1; v.stall = 1'b0;
    tbl.push_back(v);
    v.creq = 1'b0; v.cdone = 1'b0; tbl.push_back(v);
    v.ack = 1'b1; v.mrd = 32'h4444_4444; v.en = 1'b1; v.we = 4'hF; v.addr = 32'h0000_0300;
    v.wdata = 32'hAAAA_5555; tbl.push_back(v);
    v.ack = 1'b0; v.mrd = '0; v.en = 1'b0; v.we = '0; v.drd = 32'h4444_4444; v.ddone = 1'b1;
    tbl.push_back(v);
    v.dreq = 1'b0; v.ddone = 1'b0; tbl.push_back(v);

    // Loader write with ack in the sixth BUSY cycle.
    v.dreq = 1'b1; v.dwe = 4'b1100; v.daddr = 32'h0000_1003; v.dwdata = 32'h1234_0000;
    tbl.push_back(v);
    v.en = 1'b1; v.we = 4'b1100; v.addr = 32'h0000_1000; v.wdata = 32'h1234_0000;
    for (int i = 0; i < 5; i++) tbl.push_back(v);
    v.ack = 1'b1; v.mrd = 32'h0BAD_F00D; tbl.push_back(v);
    v.ack = 1'b0; v.mrd = '0; v.en = 1'b0; v.we = '0; v.drd = 32'h0BAD_F00D; v.ddone = 1'b1;
    tbl.push_back(v);
    v.dreq = 1'b0; v.ddone = 1'b0; tbl.push_back(v);

    foreach (tbl[i]) apply(tbl[i], "table", i);

    // Timeout: no ack for 16 BUSY cycles.
    v.creq = 1'b1; v.caddr = 32'h0000_0040; v.stall = 1'b1; apply(v, "to_req", 0);
    v.en = 1'b1; v.addr = 32'h0000_0040; v.wdata = '0;
    for (int i = 0; i < 16; i++) apply(v, "to_busy", i);
    v.en = 1'b0; v.crd = '0; v.cdone = 1'b1; v.err = 1'b1; v.stall = 1'b0; apply(v, "to_done", 0);
    v.creq = 1'b0; v.cdone = 1'b0; v.err = 1'b0; apply(v, "to_after", 0);

    // Ack in the limit cycle succeeds; request dropped mid-access still completes.
    v.creq = 1'b1; v.caddr = 32'h0000_0080; v.stall = 1'b1; apply(v, "ack16_req", 0);
    v.en = 1'b1; v.addr = 32'h0000_0080; apply(v, "ack16_busy", 0);
    v.creq = 1'b0; v.stall = 1'b0;
    for (int i = 1; i < 15; i++) apply(v, "ack16_busy", i);
    v.ack = 1'b1; v.mrd = 32'hCAFE_F00D; apply(v, "ack16_busy", 15);
    v.ack = 1'b0; v.mrd = '0; v.en = 1'b0; v.crd = 32'hCAFE_F00D; v.cdone = 1'b1;
    apply(v, "ack16_done", 0);
    v.cdone = 1'b0; apply(v, "ack16_after", 0);

    // Reset on the third BUSY cycle, then a normal access.
    v.dreq = 1'b1; v.dwe = 4'hF; v.daddr = 32'h0000_0500; v.dwdata = 32'h0000_0099;
    apply(v, "rst_req", 0);
    v.en = 1'b1; v.we = 4'hF; v.addr = 32'h0000_0500; v.wdata = 32'h0000_0099;
    apply(v, "rst_busy", 1);
    apply(v, "rst_busy", 2);
    v.rst = 1'b1; apply(v, "rst_busy", 3);
    v = '{default: '0};
    v.creq = 1'b1; v.caddr = 32'h0000_0010; v.stall = 1'b1; apply(v, "rst_release", 0);
    v.ack = 1'b1; v.mrd = 32'h0000_0077; v.en = 1'b1; v.addr = 32'h0000_0010;
    apply(v, "post_rst_busy", 0);
    v.ack = 1'b0; v.mrd = '0; v.en = 1'b0; v.crd = 32'h0000_0077; v.cdone = 1'b1; v.stall = 1'b0;
    apply(v, "post_rst_done", 0);
    v.creq = 1'b0; v.cdone = 1'b0; apply(v, "post_rst_idle", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, 16, cycles to wait for mem_ack before the access is aborted (legal range 2..255).
REQ-002 Port: clk  in  1  clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  synchronous, active-high reset, sampled on the rising clk edge.
REQ-004 Port: cpu_req  in  1  CPU load/store request (level); held with its fields until cpu_done.
REQ-005 Port: cpu_we  in  4  CPU byte write enables; 4'b0000 means a read.
REQ-006 Port: cpu_addr  in  32  CPU byte address.
REQ-007 Port: cpu_wdata  in  32  CPU write data, already lane-shifted.
REQ-008 Port: cpu_rdata  out  32  read word returned to the CPU.
REQ-009 Port: cpu_done  out  1  one-cycle completion pulse for the CPU.
REQ-010 Port: cpu_stall  out  1  pipeline hold = cpu_req AND NOT cpu_done (combinational).
REQ-011 Port: dma_req / dma_we / dma_addr / dma_wdata  in  1/4/32/32  loader port, same semantics as CPU.
REQ-012 Port: dma_rdata / dma_done  out  32/1  loader read data and completion pulse.
REQ-013 Port: mem_en / mem_we / mem_addr / mem_wdata  out  1/4/32/32  DMEM request, all registered.
REQ-014 Port: mem_rdata / mem_ack  in  32/1  DMEM read data, valid in the cycle mem_ack=1.
REQ-015 Port: err  out  1  one-cycle pulse with *_done when the access timed out.

Function
REQ-016 FSM states: IDLE, BUSY, RESP; exactly one access outstanding at any time.
REQ-017 IDLE with no request: stay IDLE, mem_en=0, mem_we=0.
REQ-018 IDLE with request(s): grant one, capture its we/addr/wdata, drive mem_en=1 from the next cycle, go BUSY.
REQ-019 Arbitration round-robin: single requester always wins; both requesting -> port not granted last wins; last_grant resets to DMA so CPU wins first tie.
REQ-020 mem_addr = {captured_addr[31:2], 2'b00}; mem_we, mem_wdata = captured values; all held stable throughout BUSY.
REQ-021 BUSY: 8-bit wait counter cleared on entry, +1 per cycle without mem_ack.
REQ-022 BUSY with mem_ack=1: latch mem_rdata into the granted port's rdata (reads and writes alike), drop mem_en/mem_we, go RESP.
REQ-023 BUSY with counter = TIMEOUT-1 and mem_ack=0: abort, granted rdata = 0, flag err, drop mem_en/mem_we, go RESP.
REQ-024 mem_ack in the same cycle as the timeout limit counts as success (ack priority).
REQ-025 mem_ack in IDLE or RESP is ignored.
REQ-026 RESP: assert granted port's *_done (and err if flagged) for exactly one cycle, update last_grant, return to IDLE.
REQ-027 Minimum latency: request seen in cycle N, mem_ack in N+1 -> done in N+2; next grant sampled in N+3.
REQ-028 Non-granted port's rdata holds its previous value; request dropped mid-access is not cancelled, the access completes.
REQ-029 Requests arriving in BUSY/RESP wait; done is never given to a port that was not granted.

Reset
REQ-030 reset=1 forces IDLE regardless of state, including mid-BUSY; outstanding access abandoned, no done pulse.
REQ-031 Reset values: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rdata=0, dma_rdata=0, cpu_done=0, dma_done=0, err=0, counter=0, last_grant=DMA.
REQ-032 First grant possible in the cycle after reset deasserts.

Verification
REQ-033 CPU read addr 0x0000_0106, ack after 1 cycle with mem_rdata 0xDEAD_BEEF -> mem_addr 0x0000_0104, mem_we 0, cpu_rdata 0xDEAD_BEEF, cpu_done one cycle, latency 2 cycles.
REQ-034 CPU and DMA request in the same cycle, twice in a row -> CPU served first, DMA second; repeated contention alternates grants.
REQ-035 DMA write we=4'b1100 wdata 0x1234_0000, ack delayed 5 cycles -> mem_en/mem_we/mem_wdata stable for all 6 BUSY cycles, dma_done once, cpu_done never.
REQ-036 TIMEOUT=16, mem_ack never asserted -> mem_en drops after 16 BUSY cycles, cpu_done and err pulse together, cpu_rdata 0; ack arriving on cycle 16 instead -> success, err 0.
REQ-037 reset asserted on 3rd BUSY cycle -> next cycle all outputs at reset values, no done pulse; new request after release granted normally.
REQ-038 cpu_stall follows cpu_req and falls in the cpu_done cycle; stray mem_ack in IDLE causes no done and no state change.
